// File: rtl/psm_dispatcher.sv
// Operand-pair dispatcher for the PSM: queues (A,B) pairs and issues them one job at a time. Optional DISPATCH_STATS_EN builds the IssueCount counter.
// Latency: a pair pushed in cycle N gives PsmStart in cycle N+2 at the earliest. Pairs are issued back to back, with a gap of the PSM duration plus 2 cycles.
// Backpressure: InReady falls while the FIFO is full. A job whose PSM never goes busy is dropped and sets sticky Error.

module psm_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdat,
  output logic [W-1:0]  rdat,
  output logic [CW-1:0] count,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & (cnt != '0);

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= wdat;
  end

  assign rdat  = mem[rd_ptr];
  assign count = cnt;
endmodule

module psm_dispatcher #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [7:0]                   InA,
  input  logic [7:0]                   InB,
  input  logic                         PsmReady,
  output logic                         PsmStart,
  output logic [7:0]                   PsmDin1,
  output logic [7:0]                   PsmDin2,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Busy,
  output logic                         Error,
  output logic [15:0]                  IssueCount
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  pair_t         head_dat;
  pair_t         in_dat;
  logic          fifo_full;
  logic          pop;
  logic          tmo_clr;
  logic          tmo_inc;
  logic          err_set;
  logic [TW-1:0] tmo_q;
  logic [7:0]    din1_q;
  logic [7:0]    din2_q;
  logic          error_q;

  assign in_dat = '{a: InA, b: InB};

  psm_fifo #(
    .W     ($bits(pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (InValid),
    .pop   (pop),
    .wdat  (in_dat),
    .rdat  (head_dat),
    .count (Count),
    .full  (fifo_full)
  );

  assign InReady = ~fifo_full;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tmo_clr = 1'b0;
    tmo_inc = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if ((Count != '0) && PsmReady) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        tmo_clr = 1'b1;
      end
      WAIT_BUSY: begin
        // A PSM that never leaves ready loses the job; it is not re-queued.
        if (!PsmReady) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = IDLE;
          err_set = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (PsmReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tmo_q   <= '0;
      din1_q  <= '0;
      din2_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (tmo_clr)      tmo_q <= '0;
      else if (tmo_inc) tmo_q <= tmo_q + 1'b1;
      if (pop) begin
        din1_q <= head_dat.a;
        din2_q <= head_dat.b;
      end
      if (err_set) error_q <= 1'b1;
    end
  end

  assign PsmStart = (state_q == ISSUE);
  assign Busy     = (state_q != IDLE);
  assign PsmDin1  = din1_q;
  assign PsmDin2  = din2_q;
  assign Error    = error_q;

`ifdef DISPATCH_STATS_EN
  logic [15:0] issue_cnt_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                                         issue_cnt_q <= '0;
    else if ((state_q == ISSUE) && (issue_cnt_q != 16'hFFFF)) issue_cnt_q <= issue_cnt_q + 16'd1;
  end

  assign IssueCount = issue_cnt_q;
`else
  assign IssueCount = 16'h0000;
`endif
endmodule

// File: tb/tb_psm_dispatcher.sv
// Directed bench for psm_dispatcher: a cycle table for the basic issue flow plus
// hand sequences for FIFO saturation, busy timeout, mid-job reset and issue counting.
module tb_psm_dispatcher;
  localparam int DEPTH = 4;

  logic       Clock;
  logic       Reset;
  logic       InValid;
  logic       InReady;
  logic [7:0] InA;
  logic [7:0] InB;
  logic       PsmReady;
  logic       PsmStart;
  logic [7:0] PsmDin1;
  logic [7:0] PsmDin2;
  logic [2:0] Count;
  logic       Busy;
  logic       Error;
  logic [15:0] IssueCount;

  int checks;
  int errors;
  logic prev_start;

  psm_dispatcher #(.DEPTH(DEPTH), .BUSY_TIMEOUT(8)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .InA        (InA),
    .InB        (InB),
    .PsmReady   (PsmReady),
    .PsmStart   (PsmStart),
    .PsmDin1    (PsmDin1),
    .PsmDin2    (PsmDin2),
    .Count      (Count),
    .Busy       (Busy),
    .Error      (Error),
    .IssueCount (IssueCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       r;
    logic       e_rdy;
    logic [2:0] e_cnt;
    logic       e_start;
    logic [7:0] e_d1;
    logic [7:0] e_d2;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    InValid  = 1'b0;
    PsmReady = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (PsmStart) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Model PSM: drops Ready the cycle after Start, stays busy for dur cycles.
  task automatic run_job(input int dur, output logic [7:0] d1, output logic [7:0] d2, output logic ok);
    wait_start(ok);
    d1 = PsmDin1;
    d2 = PsmDin2;
    if (!ok) return;
    tick();
    PsmReady = 1'b0;
    for (int i = 0; i < dur; i++) begin
      tick();
      chk("job_busy", Busy, 1'b1);
    end
    PsmReady = 1'b1;
    tick();
    chk("job_done_idle", Busy, 1'b0);
  endtask

  always @(negedge Clock) begin
    if (!Reset && PsmStart) begin
      checks++;
      if (prev_start) begin
        errors++;
        $display("FAIL start_back_to_back: got 1 expected 0");
      end
    end
    prev_start = PsmStart;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic       ok;
    logic [7:0] d1;
    logic [7:0] d2;

    checks     = 0;
    errors     = 0;
    prev_start = 1'b0;

    //      v     a      b      r     rdy   cnt   start d1     d2     busy  err
    vecs[0]  = '{1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 3'd1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd1, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h11, 8'h22, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'h11, 8'h22, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0};

    // Reset held with InValid asserted: nothing may be pushed.
    Reset    = 1'b1;
    InValid  = 1'b1;
    InA      = 8'h77;
    InB      = 8'h88;
    PsmReady = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", InReady, 1'b1);
    chk("rst_count", Count, 3'd0);
    chk("rst_start", PsmStart, 1'b0);
    chk("rst_din1", PsmDin1, 8'h00);
    chk("rst_din2", PsmDin2, 8'h00);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_error", Error, 1'b0);
    chk("rst_issue_count", IssueCount, 16'h0000);
    InValid = 1'b0;
    Reset   = 1'b0;

    for (int i = 0; i < NV; i++) begin
      InValid  = vecs[i].v;
      InA      = vecs[i].a;
      InB      = vecs[i].b;
      PsmReady = vecs[i].r;
      tick();
      chk($sformatf("vec%0d_in_ready", i), InReady, vecs[i].e_rdy);
      chk($sformatf("vec%0d_count", i), Count, vecs[i].e_cnt);
      chk($sformatf("vec%0d_start", i), PsmStart, vecs[i].e_start);
      chk($sformatf("vec%0d_din1", i), PsmDin1, vecs[i].e_d1);
      chk($sformatf("vec%0d_din2", i), PsmDin2, vecs[i].e_d2);
      chk($sformatf("vec%0d_busy", i), Busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_error", i), Error, vecs[i].e_err);
    end

    // Saturation: five pushes into a DEPTH=4 FIFO with the PSM held busy.
    do_reset();
    PsmReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      InValid = 1'b1;
      InA     = 8'h10 + 8'(k);
      InB     = 8'h20 + 8'(k);
      tick();
      chk($sformatf("sat_count%0d", k), Count, (k < 4) ? 3'(k + 1) : 3'd4);
    end
    InValid = 1'b0;
    chk("sat_in_ready", InReady, 1'b0);
    chk("sat_busy", Busy, 1'b0);
    PsmReady = 1'b1;
    for (int j = 0; j < 4; j++) begin
      run_job((j == 0) ? 20 : 3, d1, d2, ok);
      chk($sformatf("sat_start%0d_seen", j), ok, 1'b1);
      chk($sformatf("sat_job%0d_din1", j), d1, 8'h10 + 8'(j));
      chk($sformatf("sat_job%0d_din2", j), d2, 8'h20 + 8'(j));
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_no_fifth_start", PsmStart, 1'b0);
    end
    chk("sat_drained", Count, 3'd0);

    // Busy timeout: PSM never drops Ready; the second pair still goes out.
    do_reset();
    InValid = 1'b1;
    InA = 8'hC1;
    InB = 8'hD1;
    tick();
    InA = 8'hC2;
    InB = 8'hD2;
    tick();
    InValid = 1'b0;
    chk("tmo_start", PsmStart, 1'b1);
    chk("tmo_din1", PsmDin1, 8'hC1);
    chk("tmo_push_pop_count", Count, 3'd1);
    repeat (8) tick();
    chk("tmo_error_before", Error, 1'b0);
    chk("tmo_busy_before", Busy, 1'b1);
    tick();
    chk("tmo_error_set", Error, 1'b1);
    chk("tmo_back_idle", Busy, 1'b0);
    tick();
    chk("tmo_next_start", PsmStart, 1'b1);
    chk("tmo_next_din1", PsmDin1, 8'hC2);
    chk("tmo_next_din2", PsmDin2, 8'hD2);
    chk("tmo_error_sticky", Error, 1'b1);

    // Reset arriving during WAIT_DONE with two pairs queued.
    do_reset();
    InValid = 1'b1;
    InA = 8'h01;
    InB = 8'h02;
    tick();
    InA = 8'h03;
    InB = 8'h04;
    tick();
    InA = 8'h05;
    InB = 8'h06;
    tick();
    InValid  = 1'b0;
    PsmReady = 1'b0;
    tick();
    chk("mid_busy", Busy, 1'b1);
    chk("mid_count", Count, 3'd2);
    chk("mid_din1", PsmDin1, 8'h01);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_count", Count, 3'd0);
    chk("mid_rst_in_ready", InReady, 1'b1);
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_start", PsmStart, 1'b0);
    chk("mid_rst_din1", PsmDin1, 8'h00);
    chk("mid_rst_din2", PsmDin2, 8'h00);
    chk("mid_rst_error", Error, 1'b0);
    @(negedge Clock);
    Reset    = 1'b0;
    PsmReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rst_no_issue", PsmStart, 1'b0);
    end

    // Issue counter over three jobs.
    do_reset();
    PsmReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      InValid = 1'b1;
      InA     = 8'h40 + 8'(k);
      InB     = 8'h50 + 8'(k);
      tick();
    end
    InValid  = 1'b0;
    PsmReady = 1'b1;
    for (int j = 0; j < 3; j++) begin
      run_job(2, d1, d2, ok);
      chk($sformatf("cnt_job%0d_seen", j), ok, 1'b1);
      chk($sformatf("cnt_job%0d_din1", j), d1, 8'h40 + 8'(j));
    end
`ifdef DISPATCH_STATS_EN
    chk("issue_count", IssueCount, 16'd3);
`else
    chk("issue_count", IssueCount, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
